// File: rtl/pfd_core.sv
// Clocked phase/frequency detector: rising edges of link/vco steer a 3-state FSM with a pulse timeout.
// Define PFD_INPUT_SYNC_EN to put a two-flop synchronizer in front of edge detection.
module pfd_core #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link,
  input  logic       vco,
  output logic       up,
  output logic       dn,
  output logic       upb,
  output logic       dnb,
  output logic [1:0] setting
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DN} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_link_p1;
  logic        r_vco_p1;
  logic        r_link_prev;
  logic        r_vco_prev;
  logic [15:0] r_cnt;
  logic        r_up;
  logic        r_dn;
  logic        r_upb;
  logic        r_dnb;
  logic        r_act;
  logic        r_dir;
  logic        w_link_edge;
  logic        w_vco_edge;
  logic        w_timeout;
  logic        w_enter;

  // Input sampling stage(s)
`ifdef PFD_INPUT_SYNC_EN
  logic r_link_p0;
  logic r_vco_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_link_p0 <= 1'b0;
      r_vco_p0  <= 1'b0;
      r_link_p1 <= 1'b0;
      r_vco_p1  <= 1'b0;
    end else begin
      r_link_p0 <= link;
      r_vco_p0  <= vco;
      r_link_p1 <= r_link_p0;
      r_vco_p1  <= r_vco_p0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_link_p1 <= 1'b0;
      r_vco_p1  <= 1'b0;
    end else begin
      r_link_p1 <= link;
      r_vco_p1  <= vco;
    end
  end
`endif

  // Edge detection stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_link_prev <= 1'b0;
      r_vco_prev  <= 1'b0;
    end else begin
      r_link_prev <= r_link_p1;
      r_vco_prev  <= r_vco_p1;
    end
  end

  assign w_link_edge = r_link_p1 & ~r_link_prev;
  assign w_vco_edge  = r_vco_p1 & ~r_vco_prev;
  assign w_timeout   = (r_state != S_IDLE) && (r_cnt == CNT_LAST);
  assign w_enter     = (w_state_nxt != S_IDLE) && (w_state_nxt != r_state);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_link_edge && !w_vco_edge)      w_state_nxt = S_UP;
        else if (w_vco_edge && !w_link_edge) w_state_nxt = S_DN;
      end
      S_UP:    if (w_timeout || w_vco_edge)  w_state_nxt = S_IDLE;
      S_DN:    if (w_timeout || w_link_edge) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, pulse counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_up    <= 1'b0;
      r_dn    <= 1'b0;
      r_upb   <= 1'b1;
      r_dnb   <= 1'b1;
      r_act   <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter)
        r_cnt <= 16'd0;
      else if (w_state_nxt != S_IDLE && r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 16'd1;
      r_up  <= (w_state_nxt == S_UP);
      r_dn  <= (w_state_nxt == S_DN);
      r_upb <= (w_state_nxt != S_UP);
      r_dnb <= (w_state_nxt != S_DN);
      r_act <= (w_state_nxt != S_IDLE);
      if (w_enter)
        r_dir <= (w_state_nxt == S_DN);
    end
  end

  assign up      = r_up;
  assign dn      = r_dn;
  assign upb     = r_upb;
  assign dnb     = r_dnb;
  assign setting = {r_dir, r_act};

endmodule

// File: tb/tb_pfd_core.sv
// Scoreboard bench for pfd_core: a default-timeout instance and a TIMEOUT_CYCLES=16 instance.
// Expected output words {up,dn,upb,dnb,setting} are queued per cycle and checked by a monitor.
module tb_pfd_core;

`ifdef PFD_INPUT_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  localparam logic [5:0] I0 = 6'b001100;
  localparam logic [5:0] I1 = 6'b001110;
  localparam logic [5:0] UP = 6'b100101;
  localparam logic [5:0] DN = 6'b011011;

  logic       clk;
  logic       rst;
  logic       link, vco, link16, vco16;
  logic       up_a, dn_a, upb_a, dnb_a;
  logic [1:0] set_a;
  logic       up_b, dn_b, upb_b, dnb_b;
  logic [1:0] set_b;

  logic [5:0] q_a[$];
  logic [5:0] q_b[$];
  int         n_cmp;
  int         n_bad;
  int         cyc;

  pfd_core u_dut (
    .clk(clk), .rst(rst), .link(link), .vco(vco),
    .up(up_a), .dn(dn_a), .upb(upb_a), .dnb(dnb_a), .setting(set_a)
  );

  pfd_core #(.TIMEOUT_CYCLES(16)) u_dut16 (
    .clk(clk), .rst(rst), .link(link16), .vco(vco16),
    .up(up_b), .dn(dn_b), .upb(upb_b), .dnb(dnb_b), .setting(set_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one output word per cycle per instance, sampled mid-cycle.
  always @(negedge clk) begin
    logic [5:0] e;
    logic [5:0] got;
    if (q_a.size() > 0) begin
      e   = q_a.pop_front();
      got = {up_a, dn_a, upb_a, dnb_a, set_a};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL main cyc%0d: got %b expected %b", cyc, got, e);
      end
    end
    if (q_b.size() > 0) begin
      e   = q_b.pop_front();
      got = {up_b, dn_b, upb_b, dnb_b, set_b};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL t16 cyc%0d: got %b expected %b", cyc, got, e);
      end
    end
  end

  task automatic rep(input int n, input logic [5:0] ea, input logic [5:0] eb);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      q_a.push_back(ea);
      q_b.push_back(eb);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; link = 1'b0; vco = 1'b0; link16 = 1'b0; vco16 = 1'b0;
    rep(2, I0, I0);
    rst = 1'b0;
    rep(2, I0, I0);

    // link leads vco by 10 cycles
    link = 1'b1;
    rep(L, I0, I0);
    rep(9, UP, I0);
    vco = 1'b1;
    rep(L, UP, I0);
    rep(1, I0, I0);
    link = 1'b0; vco = 1'b0;
    rep(3, I0, I0);

    // vco leads link by 25 cycles
    vco = 1'b1;
    rep(L, I0, I0);
    rep(24, DN, I0);
    link = 1'b1;
    rep(L, DN, I0);
    rep(1, I1, I0);
    link = 1'b0; vco = 1'b0;
    rep(3, I1, I0);

    // simultaneous edges: stay idle, direction bit held
    link = 1'b1; vco = 1'b1;
    rep(L + 3, I1, I0);
    link = 1'b0; vco = 1'b0;
    rep(2, I1, I0);

    // a second link edge while in UP is ignored
    link = 1'b1;
    rep(L, I1, I0);
    rep(3, UP, I0);
    link = 1'b0;
    rep(2, UP, I0);
    link = 1'b1;
    rep(L + 2, UP, I0);
    vco = 1'b1;
    rep(L, UP, I0);
    rep(1, I0, I0);
    link = 1'b0; vco = 1'b0;
    rep(2, I0, I0);

    // reset aborts a DN pulse; vco held high across release counts as a new edge
    vco = 1'b1;
    rep(L, I0, I0);
    rep(3, DN, I0);
    rst = 1'b1;
    rep(1, I0, I0);
    rst = 1'b0;
    rep(L, I0, I0);
    rep(2, DN, I0);
    link = 1'b1;
    rep(L, DN, I0);
    rep(1, I1, I0);
    link = 1'b0; vco = 1'b0;
    rep(2, I1, I0);

    // timeout: up held exactly 16 cycles with vco quiet
    link16 = 1'b1;
    rep(L, I1, I0);
    rep(16, I1, UP);
    rep(3, I1, I0);
    link16 = 1'b0;
    rep(2, I1, I0);

    // vco edge coinciding with timeout: ends in IDLE, not DN
    link16 = 1'b1;
    rep(L, I1, I0);
    rep(16 - L, I1, UP);
    vco16 = 1'b1;
    rep(L, I1, UP);
    rep(3, I1, I0);
    link16 = 1'b0; vco16 = 1'b0;
    rep(2, I1, I0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d words left, expected 0/0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pfd_core.md
PFD_CORE -- requirements
Module: pfd_core

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 4096: the maximum number of cycles an error pulse (up or dn) may stay asserted.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port link, input, 1 bit: the reference square wave, asynchronous to clk.
REQ-005 The block SHALL have port vco, input, 1 bit: the feedback square wave, asynchronous to clk.
REQ-006 The block SHALL have port up, output, 1 bit: the reference-leads error pulse, meaning raise the frequency.
REQ-007 The block SHALL have port dn, output, 1 bit: the feedback-leads error pulse, meaning lower the frequency.
REQ-008 The block SHALL have ports upb and dnb, outputs, 1 bit each: the bitwise complements of up and dn.
REQ-009 The block SHALL have port setting, output, 2 bits: setting[0] = error pulse active (up|dn); setting[1] = direction of the last error pulse (1 = dn, 0 = up).

Function
REQ-010 link and vco SHALL be sampled by input registers; the input path SHALL be one register stage, or two stages per REQ-030.
REQ-011 A rising edge SHALL be detected when the last input-register stage is 1 and its previous value is 0; the rising edge SHALL be the only event used.
REQ-012 The block SHALL be a 3-state machine IDLE/UP/DN; up=1 only in UP, dn=1 only in DN; up and dn SHALL never both be 1.
REQ-013 IDLE: link edge only -> UP; vco edge only -> DN; both edges in the same cycle -> stay IDLE.
REQ-014 UP: vco edge -> IDLE, whether or not a link edge occurs in the same cycle; a link edge alone SHALL be ignored.
REQ-015 DN: link edge -> IDLE, whether or not a vco edge occurs in the same cycle; a vco edge alone SHALL be ignored.
REQ-016 up, dn, upb, dnb and setting SHALL be registered outputs that change only on the clk edge where the state changes.
REQ-017 Latency: up/dn SHALL assert on the clk edge immediately after the detected rising edge; with the one-register input path this is 2 clk edges after the input is first sampled high.
REQ-018 setting[0] SHALL equal up|dn in every cycle.
REQ-019 setting[1] SHALL load 0 on entry to UP and 1 on entry to DN, and SHALL hold its value through IDLE.
REQ-020 A 16-bit pulse counter SHALL clear on entry to UP/DN and increment each cycle in UP/DN.
REQ-021 When the pulse counter reaches TIMEOUT_CYCLES-1, the state SHALL be forced to IDLE on the next edge; setting[1] is kept; the counter SHALL saturate and never wrap.
REQ-022 An edge that arrives on the same cycle as a timeout SHALL be processed per REQ-014/015 with timeout priority, so the result is IDLE.

Reset
REQ-023 While rst=1 at a clk edge, state SHALL go to IDLE with up=0, dn=0, upb=1, dnb=1, setting=2'b00.
REQ-024 Reset SHALL clear the input registers, previous-value registers and the pulse counter to 0.
REQ-025 Reset mid-pulse SHALL abort the pulse on that edge.
REQ-026 An input held high across reset release SHALL register as a rising edge after release.
REQ-027 rst SHALL override every other event in the same cycle.

Configuration
REQ-030 With macro PFD_INPUT_SYNC_EN defined, each of link and vco SHALL pass through a two-flop synchronizer before edge detection, and the REQ-017 latency becomes 3 clk edges.
REQ-031 With PFD_INPUT_SYNC_EN undefined, the single input register of REQ-010 SHALL be used; all other behaviour is identical.

Verification
REQ-040 Scenario, macro off: rst, then link rises, vco rises 10 cycles later -> up=1 for 10 cycles starting 2 edges after link; setting=2'b01 while up=1, then 2'b00; dn stays 0.
REQ-041 Scenario: vco rises, link rises 25 cycles later -> dn=1 for 25 cycles, dnb=0 during that time, setting[1]=1 and held afterwards.
REQ-042 Scenario: link and vco rise in the same clk cycle -> state stays IDLE; up=dn=0; setting unchanged.
REQ-043 Scenario, TIMEOUT_CYCLES=16: link rises, vco stays 0 -> up high exactly 16 cycles, then IDLE; setting[1]=0.
REQ-044 Scenario: rst=1 for 1 cycle while dn=1 -> next edge up=0, dn=0, upb=1, dnb=1, setting=2'b00.
REQ-045 Scenario, macro on: link rises -> up asserts on the 3rd clk edge after link is first sampled high; upb = ~up in every cycle.
